ruler_search_sequencer: RTL and testbench
=========================================

Name: ruler_search_sequencer

Overview:
- Central scheduler for the mark_counter chain inside mark_assembly.
- Initialises the counters, grants the single "enabled" token to one level at a time, samples the active level's verdict and moves the token.
- Tracks placed marks, records each complete ruler found and tightens the shared limit so later solutions are shorter.
- Terminates when the search backtracks to level 0.

Parameters:
NUMPOSITIONS, 5, index of the last mark; levels 1..NUMPOSITIONS are searchable; m[0]=0 is implicit.
RESET_TIMEOUT, 16, maximum INIT cycles spent waiting for cnt_ready.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high; returns block to IDLE
start  in  1  one-cycle request to begin a search; ignored unless IDLE or DONE
init_limit  in  9  initial maximum ruler length
cnt_reset  out  1  drives the reset input of every mark_counter
cnt_ready  in  1  AND of all counters' ready
enabled  out  7  level granted this cycle; 0 = none
limit  out  9  shared limit broadcast to all counters
act_next_enabled  in  7  nextEnabled of the active level (muxed by assembly)
act_val  in  9  val of the active level
found  out  1  one-cycle pulse per complete ruler
best_length  out  9  length of the last ruler found
best_marks  out  (NUMPOSITIONS+1)*9  marks of the last ruler, m[0] in LSBs
busy  out  1  high in INIT, ISSUE, WAIT, EVAL
done  out  1  high in DONE
error  out  1  sticky until next start or reset
steps  out  32  count of EVAL cycles; saturates at all-ones

Behaviour:
- Reset values: all outputs 0, state IDLE, level register 0, marks register 0.
- IDLE:
  - On start: limit<=init_limit; clear steps, error, found, best_*; go to INIT.
- INIT:
  - cnt_reset=1, enabled=0.
  - When cnt_ready is sampled high: cnt_reset<=0, level<=1, go to ISSUE.
  - After RESET_TIMEOUT cycles without cnt_ready: error<=1, go to DONE.
- ISSUE (exactly 1 cycle): enabled=level, then go to WAIT.
- WAIT (exactly 1 cycle): enabled=0, so the counter steps only once; then go to EVAL.
- EVAL: sample act_next_enabled (n) and act_val (v); steps+1 (saturating). Let L = level.
  - n==L+1 and L<NUMPOSITIONS: marks[L]<=v, level<=n, go to ISSUE.
  - n==L+1 and L==NUMPOSITIONS (complete ruler): best_marks<={marks[0..L-1],v}, best_length<=v, found pulses on the following cycle, limit<=v-1, level stays L, go to ISSUE.
  - n==L (clash, retry): level unchanged, go to ISSUE.
  - n==L-1 and n>0 (backtrack): marks[L]<=0, level<=n, go to ISSUE.
  - n==0 (search exhausted): go to DONE.
  - Any other n: error<=1, go to DONE.
- Throughput: one counter step per 3 cycles (ISSUE, WAIT, EVAL).
- A limit update takes effect in the very next ISSUE.
- Once a ruler has been found, limit never increases.
- v==0 in the complete-ruler case cannot occur; if it does: error<=1, go to DONE, limit unchanged.
- DONE: enabled=0, done=1; outputs hold. start → INIT with the same clears as IDLE.
- start while busy: ignored.
- reset mid-search: everything returns to reset values next cycle; the counters are re-initialised only on the next start via cnt_reset.
- All width arithmetic is unsigned 9-bit; level is 7-bit.

Test Plan:
- NUMPOSITIONS=3, real mark_counter chain, init_limit=10, pulse start → found pulses twice: first best_marks 0,1,3,7 (best_length 7); then best_length 6, best_marks 0,1,4,6, limit=5; then done=1, error=0.
- Same setup, init_limit=5 → no found pulse; done=1, best_length=0, limit=5.
- Stub counter that holds cnt_ready=0, RESET_TIMEOUT=16 → cnt_reset high 16 cycles, then error=1, done=1, enabled never nonzero.
- Stub returning act_next_enabled=3 while level=1 → error=1 and DONE after that single EVAL; steps=1.
- Reset asserted during WAIT at level 2 → next cycle: enabled=0, busy=0, limit=0, steps=0. A later start re-runs INIT with cnt_reset high.
- Every ISSUE cycle is followed by enabled=0 for exactly two cycles. Check with a waveform assertion over the full NUMPOSITIONS=3 run: no two consecutive nonzero enabled cycles.

Source files
------------

// File: rtl/ruler_search_sequencer_if.sv
// Bus between the search sequencer and the mark_counter chain it schedules.
// The master side is the sequencer; the slave side is the counter assembly.
interface ruler_search_sequencer_if;
    logic       cnt_reset;
    logic       cnt_ready;
    logic [6:0] enabled;
    logic [8:0] limit;
    logic [6:0] act_next_enabled;
    logic [8:0] act_val;

    modport master (
        output cnt_reset,
        output enabled,
        output limit,
        input  cnt_ready,
        input  act_next_enabled,
        input  act_val
    );

    modport slave (
        input  cnt_reset,
        input  enabled,
        input  limit,
        output cnt_ready,
        output act_next_enabled,
        output act_val
    );
endinterface

// File: rtl/ruler_search_sequencer.sv
// Golomb-ruler search scheduler: passes the enable token between mark_counter levels,
// records each complete ruler and tightens the shared length limit.
module ruler_search_sequencer #(
    parameter int unsigned NUMPOSITIONS  = 5,
    parameter int unsigned RESET_TIMEOUT = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [8:0]                      init_limit,
    ruler_search_sequencer_if.master        chain,
    output logic                            found,
    output logic [8:0]                      best_length,
    output logic [(NUMPOSITIONS+1)*9-1:0]   best_marks,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [31:0]                     steps
);

    localparam int unsigned MW = (NUMPOSITIONS + 1) * 9;
    localparam int unsigned TW = $clog2(RESET_TIMEOUT + 1);
    localparam logic [6:0]    LastLevel = 7'(NUMPOSITIONS);
    localparam logic [TW-1:0] InitLast  = TW'(RESET_TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StInit, StIssue, StWait, StEval, StDone} state_e;

    state_e          state_q, state_d;
    logic [6:0]      level_q, level_d;
    logic [MW-1:0]   marks_q, marks_d;
    logic [8:0]      limit_q, limit_d;
    logic            cnt_reset_q, cnt_reset_d;
    logic [TW-1:0]   init_cnt_q, init_cnt_d;
    logic            found_q, found_d;
    logic [8:0]      best_length_q, best_length_d;
    logic [MW-1:0]   best_marks_q, best_marks_d;
    logic            error_q, error_d;
    logic [31:0]     steps_q, steps_d;

    logic [6:0] nxt;
    logic [8:0] val;
    logic [8:0] val_m1;

    assign nxt    = chain.act_next_enabled;
    assign val    = chain.act_val;
    assign val_m1 = val - 9'd1;

    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        marks_d       = marks_q;
        limit_d       = limit_q;
        cnt_reset_d   = cnt_reset_q;
        init_cnt_d    = init_cnt_q;
        found_d       = 1'b0;
        best_length_d = best_length_q;
        best_marks_d  = best_marks_q;
        error_d       = error_q;
        steps_d       = steps_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d       = StInit;
                    limit_d       = init_limit;
                    steps_d       = '0;
                    error_d       = 1'b0;
                    best_length_d = '0;
                    best_marks_d  = '0;
                    cnt_reset_d   = 1'b1;
                    init_cnt_d    = '0;
                    level_d       = '0;
                    marks_d       = '0;
                end
            end
            StInit: begin
                if (chain.cnt_ready) begin
                    cnt_reset_d = 1'b0;
                    level_d     = 7'd1;
                    state_d     = StIssue;
                end else if (init_cnt_q == InitLast) begin
                    cnt_reset_d = 1'b0;
                    error_d     = 1'b1;
                    state_d     = StDone;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            StIssue: state_d = StWait;
            StWait:  state_d = StEval;
            StEval: begin
                steps_d = (&steps_q) ? steps_q : steps_q + 32'd1;
                state_d = StIssue;
                if (nxt == level_q + 7'd1) begin
                    if (level_q < LastLevel) begin
                        for (int unsigned i = 1; i <= NUMPOSITIONS; i++) begin
                            if (level_q == 7'(i)) marks_d[i*9 +: 9] = val;
                        end
                        level_d = nxt;
                    end else if (val == 9'd0) begin
                        error_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        // Top field of marks_q is never written, so v takes its place.
                        best_marks_d  = {val, marks_q[MW-10:0]};
                        best_length_d = val;
                        found_d       = 1'b1;
                        if (val_m1 < limit_q) limit_d = val_m1;
                    end
                end else if (nxt == level_q) begin
                    state_d = StIssue;
                end else if (nxt == 7'd0) begin
                    state_d = StDone;
                end else if (nxt == level_q - 7'd1) begin
                    for (int unsigned i = 1; i <= NUMPOSITIONS; i++) begin
                        if (level_q == 7'(i)) marks_d[i*9 +: 9] = 9'd0;
                    end
                    level_d = nxt;
                end else begin
                    error_d = 1'b1;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            level_q       <= '0;
            marks_q       <= '0;
            limit_q       <= '0;
            cnt_reset_q   <= 1'b0;
            init_cnt_q    <= '0;
            found_q       <= 1'b0;
            best_length_q <= '0;
            best_marks_q  <= '0;
            error_q       <= 1'b0;
            steps_q       <= '0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            marks_q       <= marks_d;
            limit_q       <= limit_d;
            cnt_reset_q   <= cnt_reset_d;
            init_cnt_q    <= init_cnt_d;
            found_q       <= found_d;
            best_length_q <= best_length_d;
            best_marks_q  <= best_marks_d;
            error_q       <= error_d;
            steps_q       <= steps_d;
        end
    end

    // The token is visible only in ISSUE so each counter steps exactly once per grant.
    assign chain.enabled   = (state_q == StIssue) ? level_q : 7'd0;
    assign chain.limit     = limit_q;
    assign chain.cnt_reset = cnt_reset_q;

    assign found       = found_q;
    assign best_length = best_length_q;
    assign best_marks  = best_marks_q;
    assign error       = error_q;
    assign steps       = steps_q;
    assign busy        = (state_q == StInit) || (state_q == StIssue) ||
                         (state_q == StWait) || (state_q == StEval);
    assign done        = (state_q == StDone);

endmodule

// File: tb/tb_ruler_search_sequencer.sv
// Directed bench for ruler_search_sequencer with a behavioural mark_counter chain
// (NUMPOSITIONS=3) and two stub modes for the timeout and illegal-verdict cases.
module tb_ruler_search_sequencer;

    localparam int NP = 3;
    localparam logic [35:0] Marks1 = {9'd7, 9'd3, 9'd1, 9'd0};
    localparam logic [35:0] Marks2 = {9'd6, 9'd4, 9'd1, 9'd0};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  init_limit = 9'd0;
    logic        found, busy, done, error;
    logic [8:0]  best_length;
    logic [35:0] best_marks;
    logic [31:0] steps;

    int errors = 0;
    int checks = 0;
    int mode   = 0;   // 0: counter model, 1: never ready, 2: illegal verdict

    ruler_search_sequencer_if chain_if ();

    ruler_search_sequencer #(.NUMPOSITIONS(NP), .RESET_TIMEOUT(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .init_limit  (init_limit),
        .chain       (chain_if),
        .found       (found),
        .best_length (best_length),
        .best_marks  (best_marks),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .steps       (steps)
    );

    always #5 clock = ~clock;

    // Behavioural counter chain: each level tries the next value above its own
    // (or above the level below when fresh), backtracking past the limit.
    logic [8:0]  mval [1:NP];
    logic [6:0]  m_n = '0;
    logic [8:0]  m_v = '0;
    int          rcnt = 0;
    logic [15:0] step_res;

    function automatic logic [15:0] model_step(input logic [6:0] lvl_in, input logic [8:0] lim);
        logic [8:0]   m [0:NP];
        logic [8:0]   v;
        logic [8:0]   d;
        logic [511:0] used;
        logic         clash;
        int           lvl;
        lvl = int'(lvl_in);
        if (lvl < 1 || lvl > NP) return 16'd0;
        m[0] = 9'd0;
        for (int i = 1; i <= NP; i++) m[i] = mval[i];
        v = (m[lvl] == 9'd0) ? m[lvl-1] + 9'd1 : m[lvl] + 9'd1;
        if (v > lim) return {lvl_in - 7'd1, 9'd0};
        used  = '0;
        clash = 1'b0;
        for (int a = 0; a < lvl; a++)
            for (int b = a + 1; b < lvl; b++) used[m[b] - m[a]] = 1'b1;
        for (int a = 0; a < lvl; a++) begin
            d = v - m[a];
            if (used[d]) clash = 1'b1;
            used[d] = 1'b1;
        end
        return clash ? {lvl_in, v} : {lvl_in + 7'd1, v};
    endfunction

    always_comb step_res = model_step(chain_if.enabled, chain_if.limit);

    always @(posedge clock) begin
        if (chain_if.cnt_reset) begin
            for (int i = 1; i <= NP; i++) mval[i] <= 9'd0;
            m_n <= '0;
            m_v <= '0;
            if (rcnt < 3) rcnt <= rcnt + 1;
        end else begin
            rcnt <= 0;
            if (chain_if.enabled != 7'd0) begin
                m_n <= step_res[15:9];
                m_v <= step_res[8:0];
                for (int i = 1; i <= NP; i++)
                    if (chain_if.enabled == 7'(i))
                        mval[i] <= (step_res[15:9] < chain_if.enabled) ? 9'd0 : step_res[8:0];
            end
        end
    end

    always_comb begin
        chain_if.cnt_ready        = (rcnt >= 2);
        chain_if.act_next_enabled = m_n;
        chain_if.act_val          = m_v;
        if (mode == 1) begin
            chain_if.cnt_ready        = 1'b0;
            chain_if.act_next_enabled = 7'd0;
            chain_if.act_val          = 9'd0;
        end else if (mode == 2) begin
            chain_if.cnt_ready        = 1'b1;
            chain_if.act_next_enabled = 7'd3;
            chain_if.act_val          = 9'd5;
        end
    end

    // Monitors: consecutive-grant violations, grant cycles and found captures.
    int          en_viol = 0;
    int          en_cycles = 0;
    logic [6:0]  prev_en = '0;
    int          found_cnt = 0;
    logic [8:0]  cap_len [4];
    logic [35:0] cap_marks [4];
    logic [8:0]  cap_lim = '0;

    always @(negedge clock) begin
        prev_en <= chain_if.enabled;
        if (chain_if.enabled != 7'd0) begin
            en_cycles <= en_cycles + 1;
            if (prev_en != 7'd0) en_viol <= en_viol + 1;
        end
        if (found === 1'b1) begin
            cap_len[found_cnt % 4]   <= best_length;
            cap_marks[found_cnt % 4] <= best_marks;
            cap_lim                  <= chain_if.limit;
            found_cnt                <= found_cnt + 1;
        end
    end

    task automatic pulse_start(input logic [8:0] lim);
        @(negedge clock);
        init_limit = lim;
        start      = 1'b1;
        @(negedge clock);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (chain_if.enabled !== 7'd0) begin errors++; $display("FAIL reset_enabled: got %0d want 0", chain_if.enabled); end
        checks++; if (chain_if.cnt_reset !== 1'b0) begin errors++; $display("FAIL reset_cnt_reset: got %b want 0", chain_if.cnt_reset); end
        checks++; if (chain_if.limit !== 9'd0) begin errors++; $display("FAIL reset_limit: got %0d want 0", chain_if.limit); end
        checks++; if ({busy, done, found, error} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, found, error}); end
        checks++; if (steps !== 32'd0 || best_length !== 9'd0 || best_marks !== 36'd0) begin errors++; $display("FAIL reset_regs: got steps=%0d len=%0d marks=%h want zeros", steps, best_length, best_marks); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_search;
        int f0, v0;
        bit ok;
        mode = 0;
        f0 = found_cnt;
        v0 = en_viol;
        pulse_start(9'd10);
        checks++; if (chain_if.cnt_reset !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL search_init: got cnt_reset=%b busy=%b want 1 1", chain_if.cnt_reset, busy); end
        for (int i = 0; i < 2000 && found_cnt == f0; i++) @(negedge clock);
        pulse_start(9'd10);   // must be ignored while busy
        wait_done(5000, ok);
        @(negedge clock);
        checks++; if (!ok) begin errors++; $display("FAIL search_done_timeout: got done=%b want 1", done); end
        checks++; if (found_cnt - f0 != 2) begin errors++; $display("FAIL search_found_count: got %0d want 2", found_cnt - f0); end
        checks++; if (cap_len[f0 % 4] !== 9'd7 || cap_marks[f0 % 4] !== Marks1) begin errors++; $display("FAIL search_first: got len=%0d marks=%h want 7 %h", cap_len[f0 % 4], cap_marks[f0 % 4], Marks1); end
        checks++; if (cap_len[(f0+1) % 4] !== 9'd6 || cap_marks[(f0+1) % 4] !== Marks2) begin errors++; $display("FAIL search_second: got len=%0d marks=%h want 6 %h", cap_len[(f0+1) % 4], cap_marks[(f0+1) % 4], Marks2); end
        checks++; if (cap_lim !== 9'd5 || chain_if.limit !== 9'd5) begin errors++; $display("FAIL search_limit: got %0d/%0d want 5", cap_lim, chain_if.limit); end
        checks++; if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL search_end_flags: got done=%b error=%b busy=%b want 1 0 0", done, error, busy); end
        checks++; if (steps !== 32'd38) begin errors++; $display("FAIL search_steps: got %0d want 38", steps); end
        checks++; if (en_viol != v0) begin errors++; $display("FAIL search_enable_gap: got %0d back-to-back grants want 0", en_viol - v0); end
        checks++; if (best_length !== 9'd6) begin errors++; $display("FAIL search_hold: got %0d want 6", best_length); end
    endtask

    task automatic test_no_solution;
        int f0;
        bit ok;
        mode = 0;
        f0 = found_cnt;
        pulse_start(9'd5);
        wait_done(5000, ok);
        @(negedge clock);
        checks++; if (!ok || done !== 1'b1) begin errors++; $display("FAIL nosol_done: got done=%b want 1", done); end
        checks++; if (found_cnt != f0) begin errors++; $display("FAIL nosol_found: got %0d pulses want 0", found_cnt - f0); end
        checks++; if (best_length !== 9'd0 || chain_if.limit !== 9'd5) begin errors++; $display("FAIL nosol_vals: got len=%0d limit=%0d want 0 5", best_length, chain_if.limit); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL nosol_error: got %b want 0", error); end
    endtask

    task automatic test_timeout;
        int n, e0;
        mode = 1;
        e0 = en_cycles;
        pulse_start(9'd10);
        n = 0;
        while (chain_if.cnt_reset === 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
        end
        checks++; if (n != 16) begin errors++; $display("FAIL timeout_cycles: got %0d want 16", n); end
        checks++; if (error !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL timeout_flags: got error=%b done=%b want 1 1", error, done); end
        checks++; if (en_cycles != e0) begin errors++; $display("FAIL timeout_enabled: got %0d grants want 0", en_cycles - e0); end
    endtask

    task automatic test_bad_next;
        bit ok;
        mode = 2;
        pulse_start(9'd10);
        checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL badnext_clear: got error=%b busy=%b want 0 1", error, busy); end
        wait_done(50, ok);
        checks++; if (!ok || error !== 1'b1) begin errors++; $display("FAIL badnext_error: got done=%b error=%b want 1 1", done, error); end
        checks++; if (steps !== 32'd1) begin errors++; $display("FAIL badnext_steps: got %0d want 1", steps); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int n;
        mode = 0;
        pulse_start(9'd10);
        n = 0;
        while (chain_if.enabled !== 7'd2 && n < 500) begin
            n++;
            @(negedge clock);
        end
        checks++; if (chain_if.enabled !== 7'd2) begin errors++; $display("FAIL midreset_reach: got enabled=%0d want 2", chain_if.enabled); end
        @(negedge clock);
        checks++; if (steps !== 32'd1) begin errors++; $display("FAIL midreset_pre_steps: got %0d want 1", steps); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (chain_if.enabled !== 7'd0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_state: got en=%0d busy=%b done=%b want 0 0 0", chain_if.enabled, busy, done); end
        checks++; if (chain_if.limit !== 9'd0 || steps !== 32'd0) begin errors++; $display("FAIL midreset_regs: got limit=%0d steps=%0d want 0 0", chain_if.limit, steps); end
        reset = 1'b0;
        pulse_start(9'd10);
        checks++; if (chain_if.cnt_reset !== 1'b1) begin errors++; $display("FAIL midreset_reinit: got cnt_reset=%b want 1", chain_if.cnt_reset); end
        wait_done(5000, ok);
        checks++; if (!ok || best_length !== 9'd6 || chain_if.limit !== 9'd5) begin errors++; $display("FAIL midreset_rerun: got done=%b len=%0d limit=%0d want 1 6 5", done, best_length, chain_if.limit); end
    endtask

    initial begin
        test_reset();
        test_search();
        test_no_solution();
        test_timeout();
        test_bad_next();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
